// File: rtl/money_pkg.sv
// Shared money/note codes and the change dispenser state encoding.
// The money-entry FSM uses the same money codes.
package money_pkg;

    localparam logic [1:0] MONEY_0  = 2'b00;
    localparam logic [1:0] MONEY_10 = 2'b01;
    localparam logic [1:0] MONEY_20 = 2'b10;
    localparam logic [1:0] MONEY_30 = 2'b11;

    localparam logic [1:0] NOTE_NONE = 2'b00;
    localparam logic [1:0] NOTE_10   = 2'b01;
    localparam logic [1:0] NOTE_20   = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DISPENSE = 3'd1,
        DONE     = 3'd2,
        REJECT   = 3'd3,
        FAULT    = 3'd4
    } state_t;

    // Largest note that fits in the outstanding change; codes equal their 10-euro value.
    function automatic logic [1:0] next_note(input logic [1:0] remaining);
        return (remaining >= MONEY_20) ? NOTE_20 : NOTE_10;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Vend-side request/outcome signals plus the note valid/ack handshake.
interface change_dispenser_if;

    logic       i_start;
    logic [1:0] i_credit;
    logic [1:0] i_price;
    logic       i_note_ack;
    logic       o_note_valid;
    logic [1:0] o_note_value;
    logic       o_busy;
    logic       o_done;
    logic       o_reject;
    logic       o_fault;
    logic [1:0] o_change_out;

    // Driver side: vend controller and note mechanism.
    modport master (
        output i_start, i_credit, i_price, i_note_ack,
        input  o_note_valid, o_note_value, o_busy, o_done, o_reject, o_fault, o_change_out
    );

    // Dispenser block side.
    modport slave (
        input  i_start, i_credit, i_price, i_note_ack,
        output o_note_valid, o_note_value, o_busy, o_done, o_reject, o_fault, o_change_out
    );

endinterface

// File: rtl/change_dispenser_ack_timer.sv
// Counts cycles a note waits for its ack; flags the last allowed cycle.
module ack_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Wait counter; stops at the last allowed cycle so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/change_dispenser.sv
// Computes change after a vend and pays it out one note at a time,
// largest first, reporting done / reject / fault to the vend controller.
module change_dispenser
    import money_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_remaining;
    logic [1:0] w_remaining_nxt;
    logic [1:0] r_change_out;
    logic [1:0] w_change_nxt;
    logic [1:0] w_note;
    logic [1:0] w_rem_after;
    logic       w_in_dispense;
    logic       w_ack;
    logic       w_expired;

    assign w_in_dispense = (r_state == DISPENSE);
    assign w_ack         = w_in_dispense && bus.i_note_ack;
    assign w_note        = next_note(r_remaining);
    assign w_rem_after   = r_remaining - w_note;

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_in_dispense || w_ack),
        .i_enable  (w_in_dispense),
        .o_expired (w_expired)
    );

    // State, outstanding change and issued total.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_remaining  <= MONEY_0;
            r_change_out <= MONEY_0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_change_out <= w_change_nxt;
        end
    end

    // Next state and register updates; an ack on the last allowed cycle beats the timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_change_nxt    = r_change_out;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_credit < bus.i_price) begin
                        w_state_nxt = REJECT;
                    end else if (bus.i_credit == bus.i_price) begin
                        w_state_nxt  = DONE;
                        w_change_nxt = MONEY_0;
                    end else begin
                        w_state_nxt     = DISPENSE;
                        w_remaining_nxt = bus.i_credit - bus.i_price;
                        w_change_nxt    = MONEY_0;
                    end
                end
            end
            DISPENSE: begin
                if (w_ack) begin
                    w_remaining_nxt = w_rem_after;
                    w_change_nxt    = r_change_out + w_note;
                    if (w_rem_after == MONEY_0) begin
                        w_state_nxt = DONE;
                    end
                end else if (w_expired) begin
                    w_state_nxt = FAULT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            REJECT:  w_state_nxt = IDLE;
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.o_note_valid = w_in_dispense;
    assign bus.o_note_value = w_in_dispense ? w_note : NOTE_NONE;
    assign bus.o_busy       = w_in_dispense;
    assign bus.o_done       = (r_state == DONE);
    assign bus.o_reject     = (r_state == REJECT);
    assign bus.o_fault      = (r_state == FAULT);
    assign bus.o_change_out = r_change_out;

endmodule
